// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - DEPTH x WIDTH register bank, one load/clear/inc/shl write port, two read ports
// Define REG_BANK_BYPASS_EN to forward the pending write result onto matching read ports.
module reg_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             wr_en,
   input  logic [1:0]       wr_op,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_a_addr,
   output logic [WIDTH-1:0] rd_a_data,
   input  logic [AW-1:0]    rd_b_addr,
   output logic [WIDTH-1:0] rd_b_data,
   output logic [DEPTH-1:0] valid,
   output logic             carry,
   output logic             wr_err
);
   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_CLEAR = 2'b01,
      OP_INC   = 2'b10,
      OP_SHL   = 2'b11
   } op_e;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             carry_q, carry_d;
   logic             wr_err_q, wr_err_d;
   logic             wr_in_range, wr_fire;
   logic [WIDTH-1:0] wr_old, wr_new;
   logic             wr_new_carry, wr_new_valid;

   // DEPTH need not be a power of two, so the address space can exceed the bank
   assign wr_in_range = 32'(wr_addr) < DEPTH;
   assign wr_fire     = ce && wr_en && wr_in_range;

   always_comb begin
      wr_old = '0;
      for (int i = 0; i < DEPTH; i++)
         if (32'(wr_addr) == i) wr_old = regs_q[i];
   end

   always_comb begin
      wr_new       = wr_old;
      wr_new_carry = carry_q;
      wr_new_valid = 1'b1;
      case (op_e'(wr_op))
         OP_LOAD:  wr_new = wr_data;
         OP_CLEAR: begin
            wr_new       = '0;
            wr_new_carry = 1'b0;
            wr_new_valid = 1'b0;
         end
         OP_INC:   {wr_new_carry, wr_new} = {1'b0, wr_old} + (WIDTH+1)'(1);
         OP_SHL:   begin
            wr_new       = {wr_old[WIDTH-2:0], wr_data[0]};
            wr_new_carry = wr_old[WIDTH-1];
         end
         default:  wr_new = wr_old;
      endcase
   end

   always_comb begin
      valid_d  = valid_q;
      carry_d  = carry_q;
      wr_err_d = wr_err_q;
      for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
      if (ce) begin
         wr_err_d = wr_en && !wr_in_range;
         if (wr_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (32'(wr_addr) == i) begin
                  regs_d[i]  = wr_new;
                  valid_d[i] = wr_new_valid;
               end
            end
            carry_d = wr_new_carry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         valid_q  <= '0;
         carry_q  <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         valid_q  <= valid_d;
         carry_q  <= carry_d;
         wr_err_q <= wr_err_d;
      end
   end

   always_comb begin
      rd_a_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (32'(rd_a_addr) == i) rd_a_data = regs_q[i];
`ifdef REG_BANK_BYPASS_EN
      if (wr_fire && rd_a_addr == wr_addr) rd_a_data = wr_new;
`endif
   end

   always_comb begin
      rd_b_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (32'(rd_b_addr) == i) rd_b_data = regs_q[i];
`ifdef REG_BANK_BYPASS_EN
      if (wr_fire && rd_b_addr == wr_addr) rd_b_data = wr_new;
`endif
   end

   assign valid  = valid_q;
   assign carry  = carry_q;
   assign wr_err = wr_err_q;
endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - scoreboard bench for reg_bank, a DEPTH=4 and a DEPTH=3 instance on shared inputs
module tb_reg_bank;
   localparam logic [1:0] LD = 2'd0, CL = 2'd1, IN = 2'd2, SH = 2'd3;

   logic        clk, rst, ce, wr_en;
   logic [1:0]  wr_op, wr_addr, rd_a_addr, rd_b_addr;
   logic [15:0] wr_data;
   logic [15:0] rd_a4, rd_b4, rd_a3, rd_b3;
   logic [3:0]  valid4;
   logic [2:0]  valid3;
   logic        carry4, carry3, err4, err3;

   reg_bank #(.WIDTH(16), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a4), .rd_b_addr(rd_b_addr),
      .rd_b_data(rd_b4), .valid(valid4), .carry(carry4), .wr_err(err4));

   reg_bank #(.WIDTH(16), .DEPTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a3), .rd_b_addr(rd_b_addr),
      .rd_b_data(rd_b3), .valid(valid3), .carry(carry3), .wr_err(err3));

   typedef struct {
      logic        ce, we;
      logic [1:0]  op, addr;
      logic [15:0] data;
      logic [1:0]  ra, rb;
      logic [15:0] xa, xb;
      logic [3:0]  xv;
      logic        xc, xe3;
      logic [1:0]  special;
   } vec_t;

   typedef struct {
      int          idx;
      logic [15:0] xa, xb, xa3, xb3;
      logic [3:0]  xv;
      logic [2:0]  xv3;
      logic        xc, xe3;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_a4",  e.idx, rd_a4, e.xa);
         chk("rd_b4",  e.idx, rd_b4, e.xb);
         chk("valid4", e.idx, {12'd0, valid4}, {12'd0, e.xv});
         chk("carry4", e.idx, {15'd0, carry4}, {15'd0, e.xc});
         chk("err4",   e.idx, {15'd0, err4}, 16'd0);
         chk("rd_a3",  e.idx, rd_a3, e.xa3);
         chk("rd_b3",  e.idx, rd_b3, e.xb3);
         chk("valid3", e.idx, {13'd0, valid3}, {13'd0, e.xv3});
         chk("carry3", e.idx, {15'd0, carry3}, {15'd0, e.xc});
         chk("err3",   e.idx, {15'd0, err3}, {15'd0, e.xe3});
      end
   end

   // columns: ce we op addr data | ra rb | rd_a rd_b valid carry err3 | special
   // special 1 drops rst between edges after the sample is queued; 2 releases it before the write
   initial begin
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd2, 2'd0, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd2, 16'h1234, 2'd0, 2'd1, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd2, 2'd3, 16'h1234, 16'h0000, 4'h4, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd1, 16'hFFFF, 2'd2, 2'd0, 16'h1234, 16'h0000, 4'h4, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, IN, 2'd1, 16'h0000, 2'd2, 2'd0, 16'h1234, 16'h0000, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd1, 2'd2, 16'h0000, 16'h1234, 4'h6, 1'b1, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, IN, 2'd1, 16'h0000, 2'd2, 2'd0, 16'h1234, 16'h0000, 4'h6, 1'b1, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd1, 2'd1, 16'h0001, 16'h0001, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd0, 16'h8001, 2'd1, 2'd2, 16'h0001, 16'h1234, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, SH, 2'd0, 16'h0001, 2'd1, 2'd2, 16'h0001, 16'h1234, 4'h7, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd0, 2'd0, 16'h0003, 16'h0003, 4'h7, 1'b1, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, CL, 2'd0, 16'h0000, 2'd1, 2'd2, 16'h0001, 16'h1234, 4'h7, 1'b1, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'h0001, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b0, 1'b1, LD, 2'd3, 16'hAAAA, 2'd3, 2'd2, 16'h0000, 16'h1234, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd3, 2'd1, 16'h0000, 16'h0001, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd3, 16'h7777, 2'd0, 2'd1, 16'h0000, 16'h0001, 4'h6, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b0, 1'b0, LD, 2'd0, 16'h0000, 2'd3, 2'd2, 16'h7777, 16'h1234, 4'hE, 1'b0, 1'b1, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd3, 2'd0, 16'h7777, 16'h0000, 4'hE, 1'b0, 1'b1, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd1, 2'd1, 16'h0001, 16'h0001, 4'hE, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd1, 16'h5555, 2'd2, 2'd1, 16'h1234, 16'h0001, 4'hE, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd1, 2'd1, 16'h5555, 16'h5555, 4'hE, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd0, 16'h8000, 2'd1, 2'd2, 16'h5555, 16'h1234, 4'hE, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b1, SH, 2'd0, 16'h0000, 2'd1, 2'd2, 16'h5555, 16'h1234, 4'hF, 1'b0, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h0000, 16'h7777, 4'hF, 1'b1, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd2, 2'd3, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd1});
      vecs.push_back('{1'b1, 1'b1, LD, 2'd2, 16'h4321, 2'd0, 2'd1, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd2});
      vecs.push_back('{1'b1, 1'b0, LD, 2'd0, 16'h0000, 2'd2, 2'd0, 16'h4321, 16'h0000, 4'h4, 1'b0, 1'b0, 2'd0});
`ifdef REG_BANK_BYPASS_EN
      vecs[19].xb = 16'h5555;
`endif

      rst = 1'b0; ce = 1'b0; wr_en = 1'b0; wr_op = LD; wr_addr = 2'd0;
      wr_data = 16'h0000; rd_a_addr = 2'd0; rd_b_addr = 2'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         exp_t x;
         @(posedge clk);
         #1;
         if (vecs[i].special == 2'd2) rst = 1'b1;
         ce        = vecs[i].ce;
         wr_en     = vecs[i].we;
         wr_op     = vecs[i].op;
         wr_addr   = vecs[i].addr;
         wr_data   = vecs[i].data;
         rd_a_addr = vecs[i].ra;
         rd_b_addr = vecs[i].rb;
         x.idx = i;
         x.xa  = vecs[i].xa;
         x.xb  = vecs[i].xb;
         x.xa3 = (vecs[i].ra == 2'd3) ? 16'h0000 : vecs[i].xa;
         x.xb3 = (vecs[i].rb == 2'd3) ? 16'h0000 : vecs[i].xb;
         x.xv  = vecs[i].xv;
         x.xv3 = vecs[i].xv[2:0];
         x.xc  = vecs[i].xc;
         x.xe3 = vecs[i].xe3;
         exp_q.push_back(x);
         if (vecs[i].special == 2'd1) #1 rst = 1'b0;
      end

      @(posedge clk);
      #1 wr_en = 1'b0;
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
